// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising a fetch port and a data port onto a single
// registered-read block-RAM port using a req/ack handshake.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  state_t            state_q, state_d;
  grant_t            owner_q, owner_d;
  grant_t            last_grant_q, last_grant_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;

  logic   req_i, req_d, any_req;
  grant_t winner;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= GNT_I;
      last_grant_q <= GNT_D;
      wr_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
    end
  end

  // In RESP the owner's request is still the one just served, so mask it.
  always_comb begin
    req_i   = i_req && !(state_q == RESP && owner_q == GNT_I);
    req_d   = d_req && !(state_q == RESP && owner_q == GNT_D);
    any_req = req_i || req_d;
    if (req_i && req_d) begin
      winner = (last_grant_q == GNT_D) ? GNT_I : GNT_D;
    end else begin
      winner = req_i ? GNT_I : GNT_D;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;

    unique case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d      = ACCESS;
          owner_d      = winner;
          last_grant_d = winner;
          if (winner == GNT_I) begin
            mem_addr_d = i_addr;
            mem_we_d   = 1'b0;
            wr_d       = 1'b0;
          end else begin
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            wr_d        = d_we;
            mem_wdata_d = d_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        mem_we_d = 1'b0;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        if (owner_q == GNT_I) begin
          i_rdata_d = mem_rdata;
          i_ack_d   = 1'b1;
        end else begin
          if (!wr_q) begin
            d_rdata_d = mem_rdata;
          end
          d_ack_d = 1'b1;
        end
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single transactions plus
// hand-written contention, masking and reset sequences, with an ack scoreboard.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [3:0]  i_addr, d_addr;
  logic [31:0] d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] bram [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acks = 0;
  int ack_t[$];

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[8];

  mem_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk_in(clk_in), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Block RAM with one-cycle registered read, read-before-write.
  always @(posedge clk_in) begin
    if (ld_en) bram[ld_addr] <= ld_data;
    else if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (i_ack || d_ack) begin
      exp_t e;
      n_acks++;
      ack_t.push_back(cyc);
      checks++;
      if (i_ack && d_ack) begin
        errors++;
        $display("FAIL dual_ack: got i_ack=1 d_ack=1 expected one ack (cycle %0d)", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none (cycle %0d)", i_ack, d_ack, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_d != d_ack) begin
          errors++;
          $display("FAIL ack_port: got d_ack=%0b expected d_ack=%0b (cycle %0d)", d_ack, e.is_d, cyc);
        end else if ((d_ack ? d_rdata : i_rdata) !== e.rdata) begin
          errors++;
          $display("FAIL ack_rdata: got %h expected %h (cycle %0d)", d_ack ? d_rdata : i_rdata, e.rdata, cyc);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    logic got;
    got = 1'b0;
    @(negedge clk_in);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    exp_q.push_back('{v.is_d, v.exp_rdata});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (k == 1) begin
        check($sformatf("v%0d_access_addr", idx), 32'(mem_addr), 32'(v.addr));
        check($sformatf("v%0d_access_we", idx), 32'(mem_we), 32'(v.is_d & v.we));
        if (v.is_d && v.we) check($sformatf("v%0d_access_wdata", idx), mem_wdata, v.wdata);
      end
      if (k <= 3) check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
      if (k == 2) check($sformatf("v%0d_we_one_cycle", idx), 32'(mem_we), 32'd0);
      if (v.is_d ? d_ack : i_ack) begin
        got = 1'b1;
        check($sformatf("v%0d_latency", idx), 32'(k), 32'd3);
        break;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    if (!got) check($sformatf("v%0d_ack_timeout", idx), 32'd0, 32'd1);
    @(negedge clk_in);
    check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_ack_pulse", idx), 32'(i_ack | d_ack), 32'd0);
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (n_acks < target && n < budget) begin
      @(negedge clk_in); #1;
      n++;
    end
    if (n_acks < target) check({name, "_timeout"}, 32'(n_acks), 32'(target));
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  // Both ports request on the same edge: I must be served first, D 3 cycles later.
  task automatic sim_pair(input logic [3:0] ia, input logic [31:0] iexp,
                          input logic [3:0] da, input logic [31:0] dexp, input string name);
    int base, c0, budget;
    base = n_acks;
    @(negedge clk_in);
    c0 = cyc;
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    exp_q.push_back('{1'b0, iexp});
    exp_q.push_back('{1'b1, dexp});
    budget = 0;
    while (n_acks < base + 2 && budget < 20) begin
      @(negedge clk_in); #1;
      if (n_acks >= base + 1) i_req = 1'b0;
      budget++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    if (n_acks < base + 2) check({name, "_timeout"}, 32'(n_acks), 32'(base + 2));
    else begin
      check({name, "_first_latency"}, 32'(ack_t[base] - c0), 32'd3);
      check({name, "_d_after_i"}, 32'(ack_t[base + 1] - ack_t[base]), 32'd3);
    end
  endtask

  initial begin
    int base;
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      ld_en = 1'b1;
      ld_addr = 4'(k);
      ld_data = (k == 3) ? 32'h0000_00A5 : 32'h1000_0000 + 32'(k);
    end
    @(negedge clk_in);
    ld_en = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    @(negedge clk_in);
    reset = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 4'd3,  32'h0,          32'h0000_00A5};
    vecs[1] = '{1'b1, 1'b1, 4'd5,  32'hDEAD_BEEF,  32'h0000_0000};
    vecs[2] = '{1'b0, 1'b0, 4'd5,  32'h0,          32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 4'd3,  32'h0,          32'h0000_00A5};
    vecs[4] = '{1'b1, 1'b1, 4'd15, 32'h1234_5678,  32'h0000_00A5};
    vecs[5] = '{1'b0, 1'b0, 4'd15, 32'h0,          32'h1234_5678};
    vecs[6] = '{1'b1, 1'b0, 4'd0,  32'h0,          32'h1000_0000};
    vecs[7] = '{1'b0, 1'b0, 4'd2,  32'h0,          32'h1000_0002};
    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    do_reset();
    sim_pair(4'd1, 32'h1000_0001, 4'd2, 32'h1000_0002, "simul");

    // Continuous contention: grants must alternate I, D, I, D at 3-cycle spacing.
    @(negedge clk_in);
    base = n_acks;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{1'b0, 32'h1000_0001});
      exp_q.push_back('{1'b1, 32'h1000_0002});
    end
    i_req = 1'b1; i_addr = 4'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 4'd2;
    wait_acks(base + 6, 40, "contend");
    i_req = 1'b0; d_req = 1'b0;
    if (n_acks >= base + 6) begin
      for (int k = 1; k < 6; k++)
        check($sformatf("contend_spacing%0d", k), 32'(ack_t[base + k] - ack_t[base + k - 1]), 32'd3);
    end

    // Held req: i_req high through the cycle after i_ack starts exactly one more fetch.
    repeat (3) @(negedge clk_in);
    base = n_acks;
    exp_q.push_back('{1'b0, 32'h0000_00A5});
    exp_q.push_back('{1'b0, 32'h0000_00A5});
    i_req = 1'b1; i_addr = 4'd3;
    wait_acks(base + 1, 10, "held_first");
    @(negedge clk_in);
    @(negedge clk_in);
    #1 i_req = 1'b0;
    wait_acks(base + 2, 10, "held_second");
    repeat (10) @(negedge clk_in);
    #1;
    check("held_ack_count", 32'(n_acks - base), 32'd2);
    if (n_acks >= base + 2) check("held_spacing", 32'(ack_t[base + 1] - ack_t[base]), 32'd4);

    // Reset during a write's ACCESS cycle aborts it with no ack.
    @(negedge clk_in);
    base = n_acks;
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd7; d_wdata = 32'hCAFE_F00D;
    @(negedge clk_in);
    check("abort_we_before", 32'(mem_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_acks", 32'({i_ack, d_ack}), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    repeat (6) @(negedge clk_in);
    #1;
    check("abort_no_ack", 32'(n_acks - base), 32'd0);
    sim_pair(4'd7, 32'h1000_0007, 4'd4, 32'h1000_0004, "post_rst");

    repeat (4) @(negedge clk_in);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
